// File: rtl/hazard_sched.sv
// OTTER five-stage pipeline scheduler: per-stage stall/flush control, E-stage forwarding,
// post-reset boot flush, data-memory wait-state handling with timeout, and a stall counter.
module hazard_sched #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                lw_stall_c;
  logic                run_rules_c;

  // Forwarding: M result wins over W; forced to register file while in reset.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RST_N) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end
  end

  assign lw_stall_c = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // Next-state and Mealy stall/flush controls.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    run_rules_c = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;

    case (state_q)
      S_BOOT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushM = 1'b1;
        FlushW = 1'b1;
        if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_d    = S_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          StallM     = 1'b1;
          FlushW     = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          run_rules_c = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (MemReadyM) begin
          run_rules_c = 1'b1;
          state_d     = S_RUN;
          wait_cnt_d  = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          mem_err_d   = 1'b1;
          run_rules_c = 1'b1;
          state_d     = S_RUN;
          wait_cnt_d  = '0;
        end else begin
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          StallM     = 1'b1;
          FlushW     = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = S_BOOT;
    endcase

    // A taken branch discards the D instruction, so a load-use hazard on it is moot.
    if (run_rules_c) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    if (StallF && (state_q != S_BOOT) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares every cycle.
module tb_hazard_sched;

  localparam int unsigned CNT_W = 5;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  localparam logic [7:0] C_BOOT = 8'b1000_1111;
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LW   = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_1100;
  localparam logic [7:0] C_MEM  = 8'b1111_0001;

  logic             CLK;
  logic             RST_N;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount;
  logic [7:0]       act_ctl;

  typedef struct {
    string            nm;
    logic [7:0]       ctl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   exp_cnt = 0;
  logic exp_err = 1'b0;

  hazard_sched #(.BOOT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr), .StallCount(StallCount)
  );

  assign act_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Push this cycle's expectation; a StallF outside boot shows up in the count next cycle.
  task automatic expect_v(input string nm, input logic [7:0] ctl, input logic [1:0] fa,
                          input logic [1:0] fb, input bit boot);
    exp_t e;
    e.nm  = nm;
    e.ctl = ctl;
    e.fa  = fa;
    e.fb  = fb;
    e.err = exp_err;
    e.cnt = (exp_cnt > CMAX) ? CNT_W'(CMAX) : CNT_W'(exp_cnt);
    sb_q.push_back(e);
    if (ctl[7] && !boot) exp_cnt++;
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (act_ctl !== e.ctl) begin
          n_bad++;
          $display("FAIL %s ctl{sF,sD,sE,sM,fD,fE,fM,fW}: got %b want %b", e.nm, act_ctl, e.ctl);
        end
        if (ForwardAE !== e.fa) begin
          n_bad++;
          $display("FAIL %s ForwardAE: got %b want %b", e.nm, ForwardAE, e.fa);
        end
        if (ForwardBE !== e.fb) begin
          n_bad++;
          $display("FAIL %s ForwardBE: got %b want %b", e.nm, ForwardBE, e.fb);
        end
        if (MemErr !== e.err) begin
          n_bad++;
          $display("FAIL %s MemErr: got %b want %b", e.nm, MemErr, e.err);
        end
        if (StallCount !== e.cnt) begin
          n_bad++;
          $display("FAIL %s StallCount: got %0d want %0d", e.nm, StallCount, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors pending", sb_q.size());
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    idle();

    // Reset state, with forwarding-hit inputs that must be masked.
    tick(); RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    expect_v("reset", C_BOOT, 2'b00, 2'b00, 1'b1);
    tick(); idle(); RST_N = 1'b1;
    expect_v("boot0", C_BOOT, 2'b00, 2'b00, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick(); expect_v("boot", C_BOOT, 2'b00, 2'b00, 1'b1);
    end
    tick(); expect_v("run_first", C_IDLE, 2'b00, 2'b00, 1'b0);

    // Forwarding priority and the x0 exclusion.
    tick(); RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5;
    expect_v("fwd_m_wins", C_IDLE, 2'b10, 2'b00, 1'b0);
    tick(); RegWriteM = 1'b0;
    expect_v("fwd_w", C_IDLE, 2'b01, 2'b00, 1'b0);
    tick(); RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    expect_v("fwd_x0", C_IDLE, 2'b00, 2'b00, 1'b0);
    tick(); RdM = 5'd3; RdW = 5'd9; Rs1E = 5'd9; Rs2E = 5'd3;
    expect_v("fwd_b_m", C_IDLE, 2'b01, 2'b10, 1'b0);
    tick(); idle();

    // Load-use stall, then branch overriding it, then RdE=x0 (no hazard).
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    expect_v("lw_stall", C_LW, 2'b00, 2'b00, 1'b0);
    tick(); PCSrcE = 1'b1;
    expect_v("lw_plus_br", C_BR, 2'b00, 2'b00, 1'b0);
    tick(); PCSrcE = 1'b0; RdE = 5'd0; Rs2D = 5'd0;
    expect_v("lw_rd0", C_IDLE, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    expect_v("idle_cnt1", C_IDLE, 2'b00, 2'b00, 1'b0);

    // Memory wait: 3 stalled cycles (branch ignored), release applies the load-use rule.
    tick(); MemReqM = 1'b1; MemReadyM = 1'b0;
    expect_v("mem_w1", C_MEM, 2'b00, 2'b00, 1'b0);
    tick(); PCSrcE = 1'b1;
    expect_v("mem_w2_br", C_MEM, 2'b00, 2'b00, 1'b0);
    tick(); PCSrcE = 1'b0;
    expect_v("mem_w3", C_MEM, 2'b00, 2'b00, 1'b0);
    tick(); MemReadyM = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    expect_v("mem_release_lw", C_LW, 2'b00, 2'b00, 1'b0);
    tick(); idle();
    expect_v("mem_done", C_IDLE, 2'b00, 2'b00, 1'b0);
    tick(); MemReqM = 1'b1; MemReadyM = 1'b1;
    expect_v("mem_ready_now", C_IDLE, 2'b00, 2'b00, 1'b0);

    // Timeout: 15 stalled cycles, release on the 16th, MemErr from the next.
    for (int pass = 0; pass < 2; pass++) begin
      tick(); MemReqM = 1'b1; MemReadyM = 1'b0;
      expect_v("to_run", C_MEM, 2'b00, 2'b00, 1'b0);
      for (int i = 1; i < 15; i++) begin
        tick(); expect_v("to_wait", C_MEM, 2'b00, 2'b00, 1'b0);
      end
      tick(); expect_v("to_abort", C_IDLE, 2'b00, 2'b00, 1'b0);
      exp_err = 1'b1;
      tick(); idle();
      expect_v("to_after", C_IDLE, 2'b00, 2'b00, 1'b0);
      tick(); expect_v("to_sticky", C_IDLE, 2'b00, 2'b00, 1'b0);
    end

    // Async reset mid-MEM_WAIT: reset values before any clock edge.
    tick(); MemReqM = 1'b1; MemReadyM = 1'b0;
    expect_v("ar_run", C_MEM, 2'b00, 2'b00, 1'b0);
    tick(); expect_v("ar_wait", C_MEM, 2'b00, 2'b00, 1'b0);
    tick(); #1; RST_N = 1'b0; exp_cnt = 0; exp_err = 1'b0;
    expect_v("ar_async", C_BOOT, 2'b00, 2'b00, 1'b1);
    tick(); idle();
    expect_v("ar_hold", C_BOOT, 2'b00, 2'b00, 1'b1);
    tick(); RST_N = 1'b1;
    expect_v("ar_boot0", C_BOOT, 2'b00, 2'b00, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick(); expect_v("ar_boot", C_BOOT, 2'b00, 2'b00, 1'b1);
    end
    tick(); expect_v("ar_run_first", C_IDLE, 2'b00, 2'b00, 1'b0);

    repeat (3) @(negedge CLK);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
